// File: rtl/bram_sd_sequencer.sv
// Backup-RAM sequencer: moves 512-byte sectors between BRAM port B and the HPS SD image,
// and writes the save-format header. Owns BRAM port B for both jobs.
module bram_sd_sequencer #(
  parameter int unsigned SECT_BITS = 4,
  parameter int unsigned SLOT_BITS = 2,
  parameter int unsigned BUF_AW    = 8,
  parameter int unsigned TIMEOUT   = 1 << 24
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic                        ena,
  input  logic                        load_req,
  input  logic                        save_req,
  input  logic                        format_req,
  input  logic [SLOT_BITS-1:0]        slot,
  output logic [31:0]                 sd_lba,
  output logic                        sd_rd,
  output logic                        sd_wr,
  input  logic                        sd_ack,
  input  logic [BUF_AW-1:0]           sd_buff_addr,
  input  logic                        sd_buff_wr,
  input  logic [15:0]                 sd_buff_dout,
  output logic [SECT_BITS+BUF_AW-1:0] ram_addr,
  output logic [15:0]                 ram_din,
  output logic                        ram_we,
  output logic                        busy,
  output logic                        bk_loading,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned AW = SECT_BITS + BUF_AW;
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StFmt, StReq, StXfer, StDone} state_e;

  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [SLOT_BITS-1:0]  slot_q, slot_d;
  logic [SECT_BITS-1:0]  sector_q, sector_d;
  logic [1:0]            fmt_q, fmt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  bk_q, bk_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [31:0]           lba_q, lba_d;
  logic                  ack_q, load_q, save_q, fmt_req_q;
  // Low for the first cycle after reset so a request level held through reset is not an edge.
  logic                  armed_q;

  logic start_fmt, start_load, start_save, ack_rise, ack_fall;

  assign start_fmt  = armed_q & format_req & ~fmt_req_q;
  assign start_load = armed_q & ena & load_req & ~load_q;
  assign start_save = armed_q & ena & save_req & ~save_q;
  assign ack_rise   = sd_ack & ~ack_q;
  assign ack_fall   = ~sd_ack & ack_q;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    slot_d   = slot_q;
    sector_d = sector_q;
    fmt_d    = fmt_q;
    tmo_d    = '0;
    bk_d     = bk_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    err_d    = 1'b0;
    lba_d    = lba_q;
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_fmt) begin
          state_d  = StFmt;
          fmt_d    = 2'd0;
          dir_d    = 1'b0;
          slot_d   = slot;
          sector_d = '0;
          bk_d     = 1'b0;
        end else if (start_load || start_save) begin
          state_d  = StReq;
          dir_d    = start_load;
          slot_d   = slot;
          sector_d = '0;
          bk_d     = start_load;
          rd_d     = start_load;
          wr_d     = ~start_load;
          lba_d    = 32'(slot) << SECT_BITS;
        end
      end

      StFmt: begin
        ram_we   = 1'b1;
        ram_addr = AW'(fmt_q);
        unique case (fmt_q)
          2'd0: ram_din = 16'h5548;
          2'd1: ram_din = 16'h4D42;
          2'd2: ram_din = 16'h8800;
          2'd3: ram_din = 16'h8010;
        endcase
        fmt_d = fmt_q + 2'd1;
        if (fmt_q == 2'd3) state_d = StDone;
      end

      StReq: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = StXfer;
        end else if (tmo_q == TmoLast) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          bk_d    = 1'b0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StXfer: begin
        ram_addr = {sector_q, sd_buff_addr};
        ram_din  = sd_buff_dout;
        ram_we   = dir_q & sd_ack & sd_buff_wr;
        if (ack_fall) begin
          if (&sector_q) begin
            state_d = StDone;
          end else begin
            sector_d = sector_q + 1'b1;
            rd_d     = dir_q;
            wr_d     = ~dir_q;
            lba_d    = (32'(slot_q) << SECT_BITS) | 32'(sector_d);
            state_d  = StReq;
          end
        end
      end

      StDone: begin
        done    = 1'b1;
        bk_d    = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      dir_q     <= 1'b0;
      slot_q    <= '0;
      sector_q  <= '0;
      fmt_q     <= 2'd0;
      tmo_q     <= '0;
      bk_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      lba_q     <= '0;
      ack_q     <= 1'b0;
      load_q    <= 1'b0;
      save_q    <= 1'b0;
      fmt_req_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      slot_q    <= slot_d;
      sector_q  <= sector_d;
      fmt_q     <= fmt_d;
      tmo_q     <= tmo_d;
      bk_q      <= bk_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      lba_q     <= lba_d;
      ack_q     <= sd_ack;
      load_q    <= load_req;
      save_q    <= save_req;
      fmt_req_q <= format_req;
      armed_q   <= 1'b1;
    end
  end

  assign sd_lba     = lba_q;
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign err        = err_q;
  assign bk_loading = bk_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_bram_sd_sequencer.sv
// Directed bench for bram_sd_sequencer: load, save, format, timeout, priority and reset abort,
// with an HPS-side sector model driving sd_ack and the buffer strobes.
module tb_bram_sd_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ena, load_req, save_req, format_req;
  logic [1:0]  slot;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [7:0]  sd_buff_addr;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_dout;
  logic [11:0] ram_addr;
  logic [15:0] ram_din;
  logic        ram_we, busy, bk_loading, done, err;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  bram_sd_sequencer #(
    .SECT_BITS(4),
    .SLOT_BITS(2),
    .BUF_AW   (8),
    .TIMEOUT  (100)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ena         (ena),
    .load_req    (load_req),
    .save_req    (save_req),
    .format_req  (format_req),
    .slot        (slot),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_addr(sd_buff_addr),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_dout(sd_buff_dout),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .busy        (busy),
    .bk_loading  (bk_loading),
    .done        (done),
    .err         (err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // HPS side of one sector: wait for the request, ack, stream 256 words, release ack.
  task automatic do_sector(input logic is_load, input int unsigned base, input int unsigned s);
    int n = 0;
    logic [15:0] pat;
    while (!(is_load ? sd_rd : sd_wr) && n < 8) begin
      step();
      n++;
    end
    check("req_level", 32'(is_load ? sd_rd : sd_wr), 1);
    check("req_other", 32'(is_load ? sd_wr : sd_rd), 0);
    check("lba", sd_lba, base + s);
    check("bk_loading_xfer", 32'(bk_loading), 32'(is_load));
    sd_ack = 1'b1;
    step();
    check("req_drop", 32'(sd_rd | sd_wr), 0);
    for (int w = 0; w < 256; w++) begin
      pat          = 16'(s * 256 + w) ^ 16'hA5C3;
      sd_buff_addr = 8'(w);
      sd_buff_wr   = 1'b1;
      sd_buff_dout = pat;
      #1;
      check("ram_we", 32'(ram_we), 32'(is_load));
      check("ram_addr", 32'(ram_addr), 32'(s * 256 + w));
      if (is_load) check("ram_din", 32'(ram_din), 32'(pat));
      step();
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    step();
  endtask

  initial begin
    logic saw_wr;
    reset_n = 1'b0; ena = 1'b0; load_req = 1'b0; save_req = 1'b0; format_req = 1'b0;
    slot = 2'd0; sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_wr = 1'b0; sd_buff_dout = '0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_wr", 32'({sd_rd, sd_wr}), 0);
    check("rst_ram", 32'({ram_we, ram_addr}), 0);
    check("rst_flags", 32'({done, err, bk_loading}), 0);
    check("rst_lba", sd_lba, 0);
    reset_n = 1'b1;
    repeat (2) step();

    // 1: load slot 2
    ena = 1'b1; slot = 2'd2; load_req = 1'b1;
    step();
    load_req = 1'b0;
    check("load_busy", 32'(busy), 1);
    for (int s = 0; s < 16; s++) do_sector(1'b1, 32, s);
    check("load_done", 32'(done), 1);
    check("load_bk_in_done", 32'(bk_loading), 1);
    step();
    check("load_done_pulse", 32'(done), 0);
    check("load_bk_end", 32'(bk_loading), 0);
    check("load_idle", 32'(busy), 0);
    check("lba_hold", sd_lba, 47);

    // 2: save slot 0
    slot = 2'd0; save_req = 1'b1;
    step();
    save_req = 1'b0;
    for (int s = 0; s < 16; s++) do_sector(1'b0, 0, s);
    check("save_done", 32'(done), 1);
    step();
    check("save_idle", 32'({busy, done}), 0);

    // 3: format with ena low
    ena = 1'b0; format_req = 1'b1;
    step();
    format_req = 1'b0;
    check("fmt_w0", 32'({ram_we, ram_addr, ram_din}), {1'b1, 12'd0, 16'h5548});
    step();
    check("fmt_w1", 32'({ram_we, ram_addr, ram_din}), {1'b1, 12'd1, 16'h4D42});
    step();
    check("fmt_w2", 32'({ram_we, ram_addr, ram_din}), {1'b1, 12'd2, 16'h8800});
    step();
    check("fmt_w3", 32'({ram_we, ram_addr, ram_din}), {1'b1, 12'd3, 16'h8010});
    step();
    check("fmt_done", 32'({done, ram_we, bk_loading}), 32'b100);
    step();
    check("fmt_idle", 32'({busy, done}), 0);

    // 4: timeout, sd_ack never rises
    ena = 1'b1; slot = 2'd1; load_req = 1'b1;
    step();
    load_req = 1'b0;
    check("tmo_rd_start", 32'(sd_rd), 1);
    repeat (99) step();
    check("tmo_rd_hold", 32'({sd_rd, err}), 32'b10);
    step();
    check("tmo_rd_drop", 32'(sd_rd), 0);
    check("tmo_err", 32'(err), 1);
    check("tmo_idle", 32'({busy, bk_loading, done}), 0);
    step();
    check("tmo_err_pulse", 32'(err), 0);

    // 5: load beats save; mid-load save edge dropped; ena=0 blocks load
    slot = 2'd3; load_req = 1'b1; save_req = 1'b1;
    step();
    slot = 2'd0;
    check("prio_rd_wr", 32'({sd_rd, sd_wr}), 32'b10);
    check("prio_lba", sd_lba, 48);
    load_req = 1'b0; save_req = 1'b0;
    step();
    save_req = 1'b1;
    saw_wr = 1'b0;
    for (int i = 0; i < 150 && busy; i++) begin
      step();
      if (sd_wr) saw_wr = 1'b1;
    end
    check("prio_no_save", 32'(saw_wr), 0);
    check("prio_end_idle", 32'(busy), 0);
    save_req = 1'b0; ena = 1'b0; load_req = 1'b1;
    step();
    step();
    check("ena_block", 32'({busy, sd_rd}), 0);
    load_req = 1'b0;

    // 6: async reset during sector 7 of a save
    ena = 1'b1; slot = 2'd1; save_req = 1'b1;
    step();
    for (int s = 0; s < 7; s++) do_sector(1'b0, 16, s);
    check("rst7_wr", 32'(sd_wr), 1);
    check("rst7_lba", sd_lba, 23);
    reset_n = 1'b0;
    #1;
    check("rst7_abort", 32'({sd_wr, busy, bk_loading}), 0);
    check("rst7_flags", 32'({done, err}), 0);
    step();
    reset_n = 1'b1;
    repeat (3) step();
    check("rst7_held_level", 32'({busy, sd_wr}), 0);
    save_req = 1'b0;
    step();
    save_req = 1'b1;
    step();
    check("rst7_fresh_edge", 32'({busy, sd_wr}), 32'b11);
    check("rst7_fresh_lba", sd_lba, 16);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
